// File: rtl/tile_frame_renderer.sv
// Frame rasteriser: snapshots game state on request and streams one
// 160x120 frame of pixel writes, one per clock, row-major.
module tile_frame_renderer #(
    parameter int SCREEN_W      = 160,
    parameter int SCREEN_H      = 120,
    parameter int COL_W         = 40,
    parameter int KEY_HEIGHT    = 30,
    parameter int HITBOX_TOP    = 100,
    parameter int HITBOX_BOTTOM = 110,
    parameter logic [2:0] C_BG     = 3'b111,
    parameter logic [2:0] C_TILE   = 3'b000,
    parameter logic [2:0] C_HIT    = 3'b010,
    parameter logic [2:0] C_HITBOX = 3'b100,
    parameter logic [2:0] C_GRID   = 3'b011
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [8:0]  yoffset,
    input  logic [19:0] keys,
    input  logic [1:0]  num_hit,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic [2:0]  colour,
    output logic        plot,
    output logic        busy,
    output logic        done
);

    localparam int KEY_ROWS = 5;

    typedef enum logic [1:0] {IDLE, SCAN, FLUSH, DONE} state_t;

    state_t      state;
    logic [7:0]  cx;
    logic [6:0]  cy;
    logic [8:0]  yoff_q;
    logic [19:0] keys_q;
    logic [1:0]  nhit_q;
    logic [1:0]  col;
    logic [2:0]  pix;
    logic        grid;
    logic        hitbox;

    always_comb begin
        col = 2'd3;
        unique case (1'b1)
            (cx < 8'(COL_W)):
                col = 2'd0;
            (cx >= 8'(COL_W) && cx < 8'(2 * COL_W)):
                col = 2'd1;
            (cx >= 8'(2 * COL_W) && cx < 8'(3 * COL_W)):
                col = 2'd2;
            default:
                col = 2'd3;
        endcase
    end

    assign grid = (cx == 8'(COL_W - 1))
               || (cx == 8'(2 * COL_W - 1))
               || (cx == 8'(3 * COL_W - 1))
               || (cx == 8'(4 * COL_W - 1));

    assign hitbox = (cy >= 7'(HITBOX_TOP))
                 && (cy < 7'(HITBOX_BOTTOM));

    // Tile rows are walked top-down so the lowest row index overrides.
    always_comb begin
        logic signed [10:0] ys;
        logic signed [10:0] top;
        logic [3:0]         row;
        ys  = $signed({4'b0000, cy});
        top = '0;
        row = '0;
        pix = C_BG;
        if (grid)
            pix = C_GRID;
        if (hitbox)
            pix = C_HITBOX;
        for (int i = KEY_ROWS - 1; i >= 0; i--) begin
            top = $signed({2'b00, yoff_q})
                - $signed(11'(KEY_HEIGHT * i));
            row = keys_q[4*i +: 4];
            if (ys >= top
                && ys < top + $signed(11'(KEY_HEIGHT))
                && row[col])
                pix = (3'(i) < {1'b0, nhit_q}) ? C_HIT : C_TILE;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state  <= IDLE;
            cx     <= '0;
            cy     <= '0;
            yoff_q <= '0;
            keys_q <= '0;
            nhit_q <= '0;
            x      <= '0;
            y      <= '0;
            colour <= '0;
            plot   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            plot <= 1'b0;
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        yoff_q <= yoffset;
                        keys_q <= keys;
                        nhit_q <= num_hit;
                        cx     <= '0;
                        cy     <= '0;
                        busy   <= 1'b1;
                        state  <= SCAN;
                    end
                end
                SCAN: begin
                    x      <= cx;
                    y      <= cy;
                    colour <= pix;
                    plot   <= 1'b1;
                    if (cx == 8'(SCREEN_W - 1)) begin
                        cx <= '0;
                        cy <= cy + 7'd1;
                        if (cy == 7'(SCREEN_H - 1))
                            state <= FLUSH;
                    end else begin
                        cx <= cx + 8'd1;
                    end
                end
                FLUSH: begin
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tile_frame_renderer.sv
// Bench for tile_frame_renderer: cycle-level reference model of the
// frame stream plus literal pixel checks on captured frames.
module tb_tile_frame_renderer;

    localparam int W      = 160;
    localparam int H      = 120;
    localparam int NPIX   = W * H;
    localparam int K_DONE = NPIX + 1;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [8:0]  yoffset = '0;
    logic [19:0] keys = '0;
    logic [1:0]  num_hit = '0;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        plot;
    logic        busy;
    logic        done;

    int total = 0;
    int bad = 0;
    int plot_cnt = 0;
    int done_cnt = 0;
    int frame [NPIX];

    // model state: k counts clocks since the accepting edge
    bit          m_act = 1'b0;
    int          m_k = 0;
    logic [7:0]  m_x = '0;
    logic [6:0]  m_y = '0;
    logic [2:0]  m_c = '0;
    int          s_yo = 0;
    logic [19:0] s_keys = '0;
    int          s_nh = 0;

    always #5 clk = ~clk;

    tile_frame_renderer dut (
        .clk     (clk),
        .resetn  (resetn),
        .start   (start),
        .yoffset (yoffset),
        .keys    (keys),
        .num_hit (num_hit),
        .x       (x),
        .y       (y),
        .colour  (colour),
        .plot    (plot),
        .busy    (busy),
        .done    (done)
    );

    function automatic logic [2:0] ref_colour(input int px, input int py,
                                              input int yo,
                                              input logic [19:0] kk,
                                              input int nh);
        for (int i = 0; i < 5; i++) begin
            int top;
            top = yo - 30 * i;
            if (py >= top && py < top + 30 && kk[4 * i + px / 40])
                return (i < nh) ? 3'b010 : 3'b000;
        end
        if (py >= 100 && py < 110)
            return 3'b100;
        if (px % 40 == 39)
            return 3'b011;
        return 3'b111;
    endfunction

    initial begin : compare
        bit e_plot;
        bit e_done;
        forever begin
            @(negedge clk);
            e_plot = m_act && m_k >= 1 && m_k <= NPIX;
            e_done = m_act && m_k == K_DONE;
            total++;
            if ({busy, done, plot, x, y, colour}
                !== {m_act, e_done, e_plot, m_x, m_y, m_c}) begin
                bad++;
                $display("FAIL outputs t=%0t busy/done/plot/x/y/colour got %0d/%0d/%0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d/%0d/%0d",
                         $time, busy, done, plot, x, y, colour,
                         m_act, e_done, e_plot, m_x, m_y, m_c);
            end
            if (plot === 1'b1) begin
                plot_cnt++;
                if (x < 8'(W) && y < 7'(H))
                    frame[int'(y) * W + int'(x)] = int'(colour);
            end
            if (done === 1'b1)
                done_cnt++;
            // advance with the inputs the next rising edge will sample
            if (!resetn) begin
                m_act = 1'b0;
                m_k   = 0;
                m_x   = '0;
                m_y   = '0;
                m_c   = '0;
            end else if (!m_act) begin
                if (start) begin
                    m_act  = 1'b1;
                    m_k    = 0;
                    s_yo   = int'(yoffset);
                    s_keys = keys;
                    s_nh   = int'(num_hit);
                end
            end else if (m_k == K_DONE) begin
                m_act = 1'b0;
            end else begin
                m_k++;
            end
            if (m_act && m_k >= 1 && m_k <= NPIX) begin
                m_x = 8'((m_k - 1) % W);
                m_y = 7'((m_k - 1) / W);
                m_c = ref_colour(int'(m_x), int'(m_y), s_yo, s_keys, s_nh);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check_pix(input string nm, input int px, input int py,
                             input int exp);
        total++;
        if (frame[py * W + px] != exp) begin
            bad++;
            $display("FAIL %s pixel(%0d,%0d) got %03b expected %03b",
                     nm, px, py, frame[py * W + px], exp);
        end
    endtask

    task automatic check_val(input string nm, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic scramble_inputs();
        yoffset = 9'($urandom);
        keys    = 20'($urandom);
        num_hit = 2'($urandom);
        start   = ($urandom_range(0, 15) == 0);
    endtask

    task automatic run_frame(input string nm, input logic [8:0] yo,
                             input logic [19:0] kk, input logic [1:0] nh);
        int d0;
        int p0;
        bit seen;
        d0 = done_cnt;
        p0 = plot_cnt;
        seen = 1'b0;
        yoffset = yo;
        keys = kk;
        num_hit = nh;
        start = 1'b1;
        tick();
        for (int c = 0; c < NPIX + 100 && !seen; c++) begin
            scramble_inputs();
            tick();
            if (done_cnt != d0)
                seen = 1'b1;
        end
        start = 1'b0;
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL %s done_timeout got 0 expected 1", nm);
        end
        check_val({nm, "_plots"}, plot_cnt - p0, NPIX);
        check_val({nm, "_dones"}, done_cnt - d0, 1);
    endtask

    task automatic wait_plots(input int p0, input int n);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 4 * n && !ok; c++) begin
            tick();
            if (plot_cnt - p0 >= n)
                ok = 1'b1;
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL wait_plots got %0d expected %0d", plot_cnt - p0, n);
        end
    endtask

    initial begin : driver
        int d0;
        int p0;
        resetn = 1'b0;
        repeat (3) tick();
        resetn = 1'b1;
        repeat (5) tick();
        check_val("reset_state", int'({busy, done, plot, x, y, colour}), 0);

        run_frame("frame_a", 9'd90, 20'h00021, 2'd0);
        check_pix("a", 0, 95, 3'b000);
        check_pix("a", 0, 105, 3'b000);
        check_pix("a", 50, 105, 3'b100);
        check_pix("a", 50, 95, 3'b111);
        check_pix("a", 39, 50, 3'b011);
        check_pix("a", 39, 95, 3'b000);
        check_pix("a", 45, 60, 3'b000);
        check_pix("a", 45, 89, 3'b000);
        check_pix("a", 45, 59, 3'b111);
        check_pix("a", 45, 90, 3'b111);

        run_frame("frame_b", 9'd90, 20'h00021, 2'd1);
        check_pix("b", 0, 95, 3'b010);
        check_pix("b", 50, 105, 3'b100);
        check_pix("b", 45, 60, 3'b000);
        check_pix("b", 0, 119, 3'b010);

        run_frame("frame_c", 9'd10, 20'h00F01, 2'd0);
        check_pix("c", 0, 0, 3'b111);
        check_pix("c", 100, 5, 3'b111);
        check_pix("c", 0, 10, 3'b000);
        check_pix("c", 0, 9, 3'b111);

        // restart attempt mid-frame, then reset mid-frame
        d0 = done_cnt;
        p0 = plot_cnt;
        yoffset = 9'($urandom);
        keys = 20'($urandom);
        num_hit = 2'($urandom);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_plots(p0, 500);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_plots(p0, 1000);
        resetn = 1'b0;
        tick();
        check_val("mid_reset_plot", int'(plot), 0);
        check_val("mid_reset_busy", int'(busy), 0);
        resetn = 1'b1;
        repeat (30) tick();
        check_val("mid_reset_no_done", done_cnt - d0, 0);
        check_val("mid_reset_idle", int'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
